game_controller: RTL
====================

// Module: game_controller
// PURPOSE
//  Top-level game sequencer for Space Invaders. Consumes debounced button pulses and gameplay event pulses,
//  runs the attract/play/respawn/wave-pause/game-over FSM, and owns the lives, score and wave registers
//  that drive segment_displays. Gates player move/shoot requests toward the gameplay datapath.
// PARAMETERS
//  START_LIVES      3    lives loaded at game start (1..MAX_LIVES)
//  MAX_LIVES        9    lives saturation ceiling (fits 4 bits)
//  MAX_SCORE        99   score saturation ceiling (two-digit display)
//  EXTRA_LIFE_EVERY 50   +1 life each time score crosses a multiple of this
//  RESPAWN_TICKS    100  invulnerability time after a hit, in ticks (0.5 s at 200 Hz)
//  WAVE_TICKS       200  pause between waves, in ticks
//  OVER_TICKS       400  game-over lockout before a restart press is accepted, in ticks
// PORTS
//  clk          in   1  system clock; only clock in the block
//  arst         in   1  asynchronous reset, active-low
//  tick         in   1  one-clk-cycle strobe at 200 Hz (enable, not a clock)
//  shoot        in   1  debounced one-cycle pulse
//  left         in   1  debounced one-cycle pulse
//  right        in   1  debounced one-cycle pulse
//  alien_hit    in   1  one-cycle pulse: player bullet destroyed an alien
//  player_hit   in   1  one-cycle pulse: alien bullet struck player
//  wave_cleared in   1  one-cycle pulse: last alien of the wave destroyed
//  lives        out  4  current lives (to segment_displays)
//  score        out  7  current score, 0..MAX_SCORE (to segment_displays)
//  wave         out  4  wave number, saturates at 15
//  move_left    out  1  gated left pulse, same cycle as input
//  move_right   out  1  gated right pulse, same cycle as input
//  fire         out  1  gated shoot pulse, same cycle as input
//  new_wave     out  1  one-cycle pulse: datapath reloads alien formation
//  respawn      out  1  one-cycle pulse: datapath recentres player
//  invuln       out  1  level: player immune (RESPAWN state)
//  game_over    out  1  level: GAME_OVER state
// BEHAVIOUR
//  Reset (arst low, async): state=IDLE, lives=START_LIVES, score=0, wave=0, timer=0, all pulses/levels 0.
//  All registers update on posedge clk; outputs registered except move_left/move_right/fire (combinational gate).
//  States: IDLE, PLAYING, RESPAWN, WAVE_PAUSE, GAME_OVER.
//  IDLE: shoot -> PLAYING next cycle; load lives=START_LIVES, score=0, wave=1; pulse new_wave and respawn.
//    shoot in IDLE does NOT assert fire.
//  PLAYING: fire/move_* = inputs. alien_hit: score+1 saturating at MAX_SCORE; if new score is a nonzero
//    multiple of EXTRA_LIFE_EVERY, lives+1 saturating at MAX_LIVES (no award once score saturated).
//    player_hit: lives-1; if result 0 -> GAME_OVER (timer=OVER_TICKS) else -> RESPAWN (timer=RESPAWN_TICKS),
//    pulse respawn. wave_cleared -> WAVE_PAUSE (timer=WAVE_TICKS), wave+1 saturating at 15.
//  RESPAWN: invuln=1; player_hit ignored; alien_hit still scores; moves/fire allowed. Timer decrements on
//    tick; at tick with timer==1 -> PLAYING. wave_cleared here -> WAVE_PAUSE (as above), invuln drops.
//  WAVE_PAUSE: all gated outputs 0; all event inputs ignored. Timer expiry -> PLAYING with new_wave pulse.
//  GAME_OVER: lives=0, score frozen; gated outputs 0; events ignored. Timer counts OVER_TICKS; shoot before
//    expiry ignored; shoot after expiry -> IDLE (score kept for display until next start).
//  Simultaneous events same cycle, priority: alien_hit scored first, then player_hit, then wave_cleared.
//    player_hit+wave_cleared: life loss applied, wave incremented; next state GAME_OVER if lives 0, else
//    WAVE_PAUSE (pause supersedes respawn; respawn pulse still issued).
//    Extra life awarded on same cycle as a fatal hit counts first (3->... net unchanged, game continues).
//  left+right same cycle: both suppressed. tick coincident with a state entry does not decrement the new timer.
//  Timer width = clog2(max tick param)+1; a timer param of 0 is treated as 1.
// STRUCTURE
//  States, widths and default tick counts go in shared constants.v (included, as elsewhere).
//  One sub-module: tick_timer (load value, load strobe, tick enable -> done pulse); one instance, reloaded per state.
//  Sits between debouncer outputs and the gameplay datapath; lives/score feed segment_displays directly.
// TESTING
//  1 Reset then shoot -> PLAYING, lives=3, score=0, wave=1, new_wave+respawn pulse once, fire=0 that cycle.
//  2 50 alien_hit pulses -> score=50, lives=4; 60 more -> score=99 saturates, no further life.
//  3 3 player_hit spaced > RESPAWN_TICKS -> lives 2,1,0; GAME_OVER; shoot within 400 ticks ignored, after -> IDLE.
//  4 player_hit during RESPAWN (invuln=1) -> lives unchanged; after 100 ticks invuln=0, state PLAYING.
//  5 wave_cleared -> wave=2, fire/move gated 0 for 200 ticks, then new_wave pulse; alien_hit in pause ignored.
//  6 same-cycle alien_hit(score 49->50)+player_hit at lives=1 -> lives 1+1-1=1, RESPAWN; arst mid-RESPAWN -> IDLE defaults.

Source files
------------

// File: rtl/game_controller_pkg.sv
// Shared constants for the game sequencer:
// state encodings, default tick counts, timer sizing.
package game_controller_pkg;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PLAY = 3'd1;
   localparam logic [2:0] S_RESP = 3'd2;
   localparam logic [2:0] S_WAVE = 3'd3;
   localparam logic [2:0] S_OVER = 3'd4;

   localparam int DEF_START_LIVES = 3;
   localparam int DEF_MAX_LIVES   = 9;
   localparam int DEF_MAX_SCORE   = 99;
   localparam int DEF_EXTRA_LIFE  = 50;
   localparam int DEF_RESP_TICKS  = 100;
   localparam int DEF_WAVE_TICKS  = 200;
   localparam int DEF_OVER_TICKS  = 400;

   // Timer wide enough for the largest tick count, plus one bit.
   function automatic int tmr_width(input int a, input int b,
                                    input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      if (m < 1) m = 1;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/game_controller_tick_timer.sv
// Reloadable down-counter stepped by the 200 Hz tick.
// A load cycle ignores any coincident tick.
module game_controller_tick_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         arst,
   input  logic [W-1:0] load_val_i,
   input  logic         load_i,
   input  logic         tick_i,
   output logic         done_o,
   output logic         expired_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: load (0 treated as 1), else step down on tick.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = (load_val_i == '0) ? W'(1) : load_val_i;
      end else if (tick_i && cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign done_o    = tick_i & ~load_i & (cnt_q == W'(1));
   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/game_controller.sv
// Game sequencer: attract/play/respawn/wave-pause/game-over
// FSM owning lives, score and wave; gates player controls.
module game_controller
   import game_controller_pkg::*;
#(
   parameter int START_LIVES      = DEF_START_LIVES,
   parameter int MAX_LIVES        = DEF_MAX_LIVES,
   parameter int MAX_SCORE        = DEF_MAX_SCORE,
   parameter int EXTRA_LIFE_EVERY = DEF_EXTRA_LIFE,
   parameter int RESPAWN_TICKS    = DEF_RESP_TICKS,
   parameter int WAVE_TICKS       = DEF_WAVE_TICKS,
   parameter int OVER_TICKS       = DEF_OVER_TICKS
) (
   input  logic       clk,
   input  logic       arst,
   input  logic       tick,
   input  logic       shoot,
   input  logic       left,
   input  logic       right,
   input  logic       alien_hit,
   input  logic       player_hit,
   input  logic       wave_cleared,
   output logic [3:0] lives,
   output logic [6:0] score,
   output logic [3:0] wave,
   output logic       move_left,
   output logic       move_right,
   output logic       fire,
   output logic       new_wave,
   output logic       respawn,
   output logic       invuln,
   output logic       game_over
);

   localparam int TW = tmr_width(RESPAWN_TICKS, WAVE_TICKS,
                                 OVER_TICKS);

   localparam logic [3:0]    START_L = START_LIVES[3:0];
   localparam logic [3:0]    MAX_L   = MAX_LIVES[3:0];
   localparam logic [6:0]    MAX_S   = MAX_SCORE[6:0];
   localparam logic [6:0]    EL      = EXTRA_LIFE_EVERY[6:0];
   localparam logic [TW-1:0] RSP_T   = TW'(RESPAWN_TICKS);
   localparam logic [TW-1:0] WAV_T   = TW'(WAVE_TICKS);
   localparam logic [TW-1:0] OVR_T   = TW'(OVER_TICKS);

   logic [2:0]    state_q, state_d;
   logic [3:0]    lives_q, lives_d;
   logic [6:0]    score_q, score_d;
   logic [3:0]    wave_q, wave_d;
   logic          nw_q, nw_d;
   logic          rs_q, rs_d;
   logic          inv_q, go_q;
   logic          t_load;
   logic [TW-1:0] t_val;
   logic          t_done, t_exp;
   logic [3:0]    lives_t;
   logic [6:0]    score_inc;
   logic          award, dead, active;

   game_controller_tick_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .arst       (arst),
      .load_val_i (t_val),
      .load_i     (t_load),
      .tick_i     (tick),
      .done_o     (t_done),
      .expired_o  (t_exp)
   );

   assign score_inc = score_q + 7'd1;
   assign award     = (score_inc % EL) == 7'd0;

   // FSM next state, counter updates and timer reloads.
   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      score_d = score_q;
      wave_d  = wave_q;
      nw_d    = 1'b0;
      rs_d    = 1'b0;
      t_load  = 1'b0;
      t_val   = '0;
      lives_t = lives_q;
      dead    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (shoot) begin
               state_d = S_PLAY;
               lives_d = START_L;
               score_d = 7'd0;
               wave_d  = 4'd1;
               nw_d    = 1'b1;
               rs_d    = 1'b1;
            end
         end
         S_PLAY, S_RESP: begin
            if (alien_hit && score_q < MAX_S) begin
               score_d = score_inc;
               if (award && lives_t < MAX_L)
                  lives_t = lives_t + 4'd1;
            end
            if (state_q == S_PLAY && player_hit) begin
               lives_t = lives_t - 4'd1;
               if (lives_t == 4'd0) begin
                  dead    = 1'b1;
                  state_d = S_OVER;
                  t_load  = 1'b1;
                  t_val   = OVR_T;
               end else begin
                  state_d = S_RESP;
                  t_load  = 1'b1;
                  t_val   = RSP_T;
                  rs_d    = 1'b1;
               end
            end
            if (wave_cleared) begin
               if (wave_q != 4'd15) wave_d = wave_q + 4'd1;
               if (!dead) begin
                  state_d = S_WAVE;
                  t_load  = 1'b1;
                  t_val   = WAV_T;
               end
            end else if (state_q == S_RESP && t_done) begin
               state_d = S_PLAY;
            end
            lives_d = lives_t;
         end
         S_WAVE: begin
            if (t_done) begin
               state_d = S_PLAY;
               nw_d    = 1'b1;
            end
         end
         S_OVER: begin
            lives_d = 4'd0;
            if (shoot && t_exp) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, counters and registered status outputs.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q <= S_IDLE;
         lives_q <= START_L;
         score_q <= 7'd0;
         wave_q  <= 4'd0;
         nw_q    <= 1'b0;
         rs_q    <= 1'b0;
         inv_q   <= 1'b0;
         go_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         lives_q <= lives_d;
         score_q <= score_d;
         wave_q  <= wave_d;
         nw_q    <= nw_d;
         rs_q    <= rs_d;
         inv_q   <= (state_d == S_RESP);
         go_q    <= (state_d == S_OVER);
      end
   end

   assign active     = (state_q == S_PLAY) | (state_q == S_RESP);
   assign fire       = active & shoot;
   assign move_left  = active & left & ~right;
   assign move_right = active & right & ~left;

   assign lives     = lives_q;
   assign score     = score_q;
   assign wave      = wave_q;
   assign new_wave  = nw_q;
   assign respawn   = rs_q;
   assign invuln    = inv_q;
   assign game_over = go_q;

endmodule
